i2c_slave_rx: RTL and testbench

I2C slave receive front-end feeding the SPI master stage. Takes raw SDA/SCL pins, synchronises and glitch-filters them, and detects START/STOP. Matches a 7-bit write address, shifts in data bytes MSB-first and drives open-drain ACK/NACK. Hands each byte downstream over a valid/ready interface, with frame markers for SPI chip-select control.

---
 rtl/i2c_slave_rx.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// I2C slave receive front-end: pin sync/filter, START/STOP detect,
// write-address match, byte shift-in with ACK/NACK and valid/ready output.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN = 3
) (
    input  logic       i2c_wb_clk_i,
    input  logic       i2c_wb_rst_i,
    input  logic       i2c_data_in,
    input  logic       i2c_clk_in,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       start_o,
    output logic       stop_o,
    output logic       frame_o,
    output logic       ovf_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    // Synchroniser and filter history share one shift chain per pin.
    localparam int PW = SYNC_STAGES + FILTER_LEN - 1;

    logic [PW-1:0]         sda_pipe, scl_pipe;
    logic [FILTER_LEN-1:0] sda_win, scl_win;
    logic                  sda_f, scl_f, sda_q, scl_q;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]            state;
    logic [2:0]            bit_cnt;
    logic [6:0]            shreg;
    logic [7:0]            byte_in;
    logic                  ack_pend, ack_phase, accept;

    assign sda_win = sda_pipe[PW-1 -: FILTER_LEN];
    assign scl_win = scl_pipe[PW-1 -: FILTER_LEN];

    always_ff @(posedge i2c_wb_clk_i) begin
        if (i2c_wb_rst_i) begin
            sda_pipe <= '1;
            scl_pipe <= '1;
            sda_f    <= 1'b1;
            scl_f    <= 1'b1;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
        end else begin
            sda_pipe <= {sda_pipe[PW-2:0], i2c_data_in};
            scl_pipe <= {scl_pipe[PW-2:0], i2c_clk_in};
            if (&sda_win)
                sda_f <= 1'b1;
            else if (~|sda_win)
                sda_f <= 1'b0;
            if (&scl_win)
                scl_f <= 1'b1;
            else if (~|scl_win)
                scl_f <= 1'b0;
            sda_q <= sda_f;
            scl_q <= scl_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_in   = {shreg, sda_f};
    assign accept    = ~rx_valid_o | rx_ready_i;

    always_ff @(posedge i2c_wb_clk_i) begin
        if (i2c_wb_rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ack_pend   <= 1'b0;
            ack_phase  <= 1'b0;
            sda_oe_o   <= 1'b0;
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            frame_o    <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            start_o <= 1'b0;
            stop_o  <= 1'b0;
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;
            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                shreg     <= '0;
                ack_phase <= 1'b0;
                sda_oe_o  <= 1'b0;
                start_o   <= 1'b1;
                frame_o   <= 1'b0;
                ovf_o     <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                ack_phase <= 1'b0;
                sda_oe_o  <= 1'b0;
                stop_o    <= 1'b1;
                frame_o   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0])
                                state <= ADDR_ACK;
                            else
                                state <= IGNORE;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_oe_o  <= 1'b1;
                            frame_o   <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            sda_oe_o  <= 1'b0;
                            state     <= DATA;
                        end
                    end
                    DATA: if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state    <= DATA_ACK;
                            ack_pend <= accept;
                            if (accept) begin
                                rx_data_o  <= byte_in;
                                rx_valid_o <= 1'b1;
                            end else begin
                                ovf_o <= 1'b1;
                            end
                        end
                    end
                    DATA_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_oe_o  <= ack_pend;
                        end else begin
                            ack_phase <= 1'b0;
                            sda_oe_o  <= 1'b0;
                            state     <= DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged I2C master on a
// wired-AND SDA line, with handshake/pulse monitors and a check task.
module tb_i2c_slave_rx;

    localparam int Q = 8;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA_ACK = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_sda = 1'b1;
    logic       m_scl = 1'b1;
    logic       ready = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, start_p, stop_p, frame, ovf;

    int n_tests = 0;
    int n_fail = 0;
    int n_start = 0, n_stop = 0, n_hs = 0, n_vrise = 0;
    logic [7:0] got [0:15];
    logic       v_q = 1'b0;
    logic       ack;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_rx dut (
        .i2c_wb_clk_i(clk),
        .i2c_wb_rst_i(rst),
        .i2c_data_in (sda_bus),
        .i2c_clk_in  (m_scl),
        .sda_oe_o    (sda_oe),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (ready),
        .start_o     (start_p),
        .stop_o      (stop_p),
        .frame_o     (frame),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (start_p) n_start++;
            if (stop_p) n_stop++;
            if (rx_valid && !v_q) n_vrise++;
            if (rx_valid && ready) begin
                if (n_hs < 16) got[n_hs] = rx_data;
                n_hs++;
            end
        end
        v_q = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b1; wait_cyc(Q);
    endtask

    task automatic clk_bit(input logic b, input bit glitch,
                           output logic oe);
        m_sda = b; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        oe = sda_oe;
        wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
        if (glitch) begin
            m_scl = 1'b1; wait_cyc(1);
            m_scl = 1'b0; wait_cyc(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gbit,
                             output logic a);
        logic oe;
        for (int i = 7; i >= 0; i--)
            clk_bit(d[i], (i == gbit), oe);
        clk_bit(1'b1, 1'b0, a);
    endtask

    initial begin
        logic oe;
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(4);
        check("rst_oe", sda_oe, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_frame", frame, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", dut.state, S_IDLE);
        check("rst_start", n_start, 0);

        // normal write of two bytes, sink always ready
        i2c_start();
        send_byte(8'h84, -1, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_frame", frame, 1);
        send_byte(8'hA5, -1, ack);
        check("t1_ack_a5", ack, 1);
        send_byte(8'h3C, -1, ack);
        check("t1_ack_3c", ack, 1);
        check("t1_frame_pre_stop", frame, 1);
        i2c_stop();
        check("t1_hs", n_hs, 2);
        check("t1_b0", got[0], 8'hA5);
        check("t1_b1", got[1], 8'h3C);
        check("t1_vrise", n_vrise, 2);
        check("t1_start", n_start, 1);
        check("t1_stop", n_stop, 1);
        check("t1_frame_post", frame, 0);
        check("t1_state", dut.state, S_IDLE);

        // wrong address
        i2c_start();
        send_byte(8'h86, -1, ack);
        check("t2_nack", ack, 0);
        check("t2_state", dut.state, S_IGNORE);
        check("t2_frame", frame, 0);
        i2c_stop();
        check("t2_idle", dut.state, S_IDLE);
        check("t2_vrise", n_vrise, 2);

        // read request to own address
        i2c_start();
        send_byte(8'h85, -1, ack);
        check("t3_nack", ack, 0);
        check("t3_state", dut.state, S_IGNORE);
        i2c_stop();
        check("t3_vrise", n_vrise, 2);

        // sink stalled: second byte overflows
        ready = 1'b0;
        i2c_start();
        send_byte(8'h84, -1, ack);
        check("t4_addr_ack", ack, 1);
        send_byte(8'h11, -1, ack);
        check("t4_ack_11", ack, 1);
        send_byte(8'h22, -1, ack);
        check("t4_nack_22", ack, 0);
        check("t4_ovf", ovf, 1);
        check("t4_data", rx_data, 8'h11);
        check("t4_valid", rx_valid, 1);
        i2c_stop();
        check("t4_ovf_stop", ovf, 1);
        check("t4_valid_stop", rx_valid, 1);
        ready = 1'b1;
        wait_cyc(3);
        check("t4_drain_hs", n_hs, 3);
        check("t4_drain_b", got[2], 8'h11);
        check("t4_valid_clr", rx_valid, 0);

        // glitch mid-byte, partial byte, repeated START
        i2c_start();
        check("t5_ovf_clr", ovf, 0);
        send_byte(8'h84, -1, ack);
        check("t5_addr_ack", ack, 1);
        send_byte(8'h96, 4, ack);
        check("t5_ack_96", ack, 1);
        check("t5_b96", got[3], 8'h96);
        for (int i = 0; i < 4; i++)
            clk_bit(i[0], 1'b0, oe);
        i2c_start();
        check("t5_frame_rs", frame, 0);
        send_byte(8'h84, -1, ack);
        check("t5_rs_ack", ack, 1);
        send_byte(8'h5A, -1, ack);
        check("t5_ack_5a", ack, 1);
        check("t5_hs", n_hs, 5);
        check("t5_b5a", got[4], 8'h5A);
        i2c_stop();

        // reset while slave is driving the data ACK
        i2c_start();
        send_byte(8'h84, -1, ack);
        for (int i = 7; i >= 0; i--)
            clk_bit(1'(8'h77 >> i), 1'b0, oe);
        check("t6_oe_pre", sda_oe, 1);
        check("t6_state_pre", dut.state, S_DATA_ACK);
        rst = 1'b1;
        wait_cyc(1);
        check("t6_oe", sda_oe, 0);
        check("t6_state", dut.state, S_IDLE);
        check("t6_valid", rx_valid, 0);
        rst = 1'b0;
        wait_cyc(Q);
        i2c_stop();
        check("t6_idle", dut.state, S_IDLE);
        check("tot_start", n_start, 7);
        check("tot_stop", n_stop, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
